// File: rtl/wb_stage_param.sv
// Writeback stage: selects one of SRC_N result sources, registers it and drives the
// register-file write port via valid/ready. Optional byte-load extension: WB_BYTE_LOAD_EN.
module wb_stage_param #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SRC_N   = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned REG_AW  = 3,
  parameter int unsigned R0_ZERO = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SRC_N*DATA_W-1:0] in_src,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_regwrite,
  input  logic [REG_AW-1:0]       in_waddr,
`ifdef WB_BYTE_LOAD_EN
  input  logic                    in_bytesel,
  input  logic                    in_signed,
`endif
  output logic                    rf_we,
  output logic [REG_AW-1:0]       rf_waddr,
  output logic [DATA_W-1:0]       rf_wdata,
  input  logic                    rf_ready,
  output logic                    fwd_valid,
  output logic [REG_AW-1:0]       fwd_addr,
  output logic [DATA_W-1:0]       fwd_data,
  output logic [CNT_W-1:0]        retire_cnt,
  output logic                    err_sel
);

  logic              r_out_valid;
  logic              r_regwrite;
  logic [REG_AW-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_retire_cnt;
  logic              r_err_sel;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_drain;
  logic              w_sel_oob;
  logic              w_r0_drop;
  logic              w_we;
  logic [DATA_W-1:0] w_sel_data;

  assign w_in_ready = ~r_out_valid | rf_ready;
  assign w_accept   = in_valid & w_in_ready;
  assign w_drain    = r_out_valid & rf_ready;

  // Out-of-range selects (possible when 2**SEL_W > SRC_N) yield zero data.
  always_comb begin
    w_sel_data = '0;
    w_sel_oob  = (32'(in_sel) >= SRC_N);
    for (int unsigned k = 0; k < SRC_N; k++) begin
      if (32'(in_sel) == k) w_sel_data = in_src[k*DATA_W +: DATA_W];
    end
`ifdef WB_BYTE_LOAD_EN
    if ((in_sel == '0) && in_bytesel) begin
      w_sel_data = in_signed ? {{(DATA_W-8){in_src[7]}}, in_src[7:0]}
                             : {{(DATA_W-8){1'b0}}, in_src[7:0]};
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_regwrite   <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_retire_cnt <= '0;
      r_err_sel    <= 1'b0;
    end else begin
      r_out_valid <= w_accept | (r_out_valid & ~rf_ready);
      if (w_accept) begin
        r_regwrite <= in_regwrite;
        r_waddr    <= in_waddr;
        r_wdata    <= w_sel_data;
        if (w_sel_oob) r_err_sel <= 1'b1;
      end
      if (w_drain) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign w_r0_drop = (R0_ZERO != 0) && (r_waddr == '0);
  assign w_we      = r_out_valid & r_regwrite & ~w_r0_drop;

  assign in_ready   = w_in_ready;
  assign rf_we      = w_we;
  assign rf_waddr   = r_waddr;
  assign rf_wdata   = r_wdata;
  assign fwd_valid  = w_we;
  assign fwd_addr   = r_waddr;
  assign fwd_data   = r_wdata;
  assign retire_cnt = r_retire_cnt;
  assign err_sel    = r_err_sel;

endmodule

// File: tb/tb_wb_stage_param.sv
// Self-checking bench for wb_stage_param (SRC_N=4, SEL_W=3, CNT_W=4): directed table,
// hand sequences for stall/reset/wrap, and randomized traffic against a queue model.
module tb_wb_stage_param;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_src;
  logic [2:0]    in_sel;
  logic          in_regwrite;
  logic [AW-1:0] in_waddr;
  logic          in_bytesel;
  logic          in_signed;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          rf_ready;
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;
  logic [3:0]    retire_cnt;
  logic          err_sel;

  wb_stage_param #(
    .DATA_W(16), .SRC_N(4), .SEL_W(3), .REG_AW(3), .R0_ZERO(1), .CNT_W(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src), .in_sel(in_sel),
    .in_regwrite(in_regwrite), .in_waddr(in_waddr),
`ifdef WB_BYTE_LOAD_EN
    .in_bytesel(in_bytesel), .in_signed(in_signed),
`endif
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .retire_cnt(retire_cnt), .err_sel(err_sel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef WB_BYTE_LOAD_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the stage is a one-entry buffer between upstream and the RF.
  typedef struct { bit rw; logic [AW-1:0] wa; logic [DW-1:0] wd; } op_t;
  op_t           pend_q[$];
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int            m_cnt;
  bit            m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [63:0] src, input int sel,
                                             input bit bs, input bit sg);
    logic [DW-1:0] w;
    if (sel >= 4) return '0;
    w = 16'(src >> (sel * 16));
    if (BYTE_EN && sel == 0 && bs) begin
      w = sg ? 16'($signed(w[7:0])) : {8'h00, w[7:0]};
    end
    return w;
  endfunction

  function automatic bit m_we();
    if (pend_q.size() == 0) return 1'b0;
    return pend_q[0].rw && (pend_q[0].wa != 0);
  endfunction

  task automatic model_reset();
    pend_q.delete();
    m_waddr = '0;
    m_wdata = '0;
    m_cnt   = 0;
    m_err   = 1'b0;
  endtask

  task automatic check_outputs();
    chk("rf_we",      {31'd0, rf_we},     {31'd0, m_we()});
    chk("fwd_valid",  {31'd0, fwd_valid}, {31'd0, m_we()});
    chk("rf_waddr",   32'(rf_waddr),      32'(m_waddr));
    chk("fwd_addr",   32'(fwd_addr),      32'(m_waddr));
    chk("rf_wdata",   32'(rf_wdata),      32'(m_wdata));
    chk("fwd_data",   32'(fwd_data),      32'(m_wdata));
    chk("retire_cnt", 32'(retire_cnt),    32'(m_cnt));
    chk("err_sel",    {31'd0, err_sel},   {31'd0, m_err});
  endtask

  // One clock: drive inputs, check in_ready, advance model, check registered outputs.
  task automatic step(input bit v, input logic [63:0] src, input logic [2:0] sel,
                      input bit rw, input logic [AW-1:0] wa, input bit rr,
                      input bit bs, input bit sg);
    bit rdy;
    op_t e;
    in_valid = v; in_src = src; in_sel = sel; in_regwrite = rw; in_waddr = wa;
    rf_ready = rr; in_bytesel = bs; in_signed = sg;
    #1;
    rdy = (pend_q.size() == 0) || rr;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    if (pend_q.size() != 0 && rr) begin
      void'(pend_q.pop_front());
      m_cnt = (m_cnt + 1) % 16;
    end
    if (v && rdy) begin
      e.rw = rw; e.wa = wa;
      e.wd = exp_data(src, int'(sel), in_bytesel, in_signed);
      pend_q.push_back(e);
      m_waddr = wa; m_wdata = e.wd;
      if (sel >= 4) m_err = 1'b1;
    end
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  function automatic logic [63:0] alu_src(input logic [DW-1:0] alu);
    return {16'hC3C3, 16'hB2B2, alu, 16'hA0A0};
  endfunction

  // Reset asserted off-edge with in_valid held high; released one cycle later.
  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b1; rf_ready = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clock); #1;
    @(posedge clock); #1;
    check_outputs();
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  typedef struct {
    bit v; logic [DW-1:0] alu; logic [AW-1:0] wa; bit rr;
    bit e_we; logic [AW-1:0] e_wa; logic [DW-1:0] e_wd; int e_cnt;
  } vec_t;
  vec_t tbl[5];

  initial begin
    tbl[0] = '{1'b1, 16'h1234, 3'd1, 1'b1, 1'b1, 3'd1, 16'h1234, 0};
    tbl[1] = '{1'b1, 16'h1235, 3'd2, 1'b1, 1'b1, 3'd2, 16'h1235, 1};
    tbl[2] = '{1'b1, 16'h1236, 3'd3, 1'b1, 1'b1, 3'd3, 16'h1236, 2};
    tbl[3] = '{1'b1, 16'h1237, 3'd4, 1'b1, 1'b1, 3'd4, 16'h1237, 3};
    tbl[4] = '{1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 3'd4, 16'h1237, 4};

    reset_n = 1'b0; in_valid = 1'b0; in_src = '0; in_sel = '0; in_regwrite = 1'b0;
    in_waddr = '0; rf_ready = 1'b0; in_bytesel = 1'b0; in_signed = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Back-to-back stream, full throughput
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].v, alu_src(tbl[i].alu), 3'd1, 1'b1, tbl[i].wa, tbl[i].rr, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_we", i),  {31'd0, rf_we},  {31'd0, tbl[i].e_we});
      chk($sformatf("tbl%0d_wa", i),  32'(rf_waddr),   32'(tbl[i].e_wa));
      chk($sformatf("tbl%0d_wd", i),  32'(rf_wdata),   32'(tbl[i].e_wd));
      chk($sformatf("tbl%0d_cnt", i), 32'(retire_cnt), 32'(tbl[i].e_cnt));
    end

    // Backpressure: one op held for 3 stalled cycles, next op loads on the drain edge
    step(1'b1, alu_src(16'hBEEF), 3'd1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, alu_src(16'hCAFE), 3'd1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_wdata",    32'(rf_wdata),     32'h0000BEEF);
      chk("stall_fwd_data", 32'(fwd_data),     32'h0000BEEF);
      chk("stall_fwd_addr", 32'(fwd_addr),     32'd5);
    end
    step(1'b1, alu_src(16'hCAFE), 3'd1, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    chk("bp_next_wdata", 32'(rf_wdata),   32'h0000CAFE);
    chk("bp_cnt",        32'(retire_cnt), 32'd5);

    // Register 0 write suppressed but retired; out-of-range select
    step(1'b1, alu_src(16'h5555), 3'd1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("r0_we", {31'd0, rf_we}, 32'd0);
    step(1'b1, alu_src(16'h7777), 3'd5, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    chk("oob_wdata", 32'(rf_wdata), 32'd0);
    chk("oob_err",   {31'd0, err_sel}, 32'd1);
    chk("r0_cnt",    32'(retire_cnt), 32'd7);
    step(1'b1, alu_src(16'h1111), 3'd2, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("err_sticky", {31'd0, err_sel}, 32'd1);
    chk("cnt_9",      32'(retire_cnt), 32'd9);

`ifdef WB_BYTE_LOAD_EN
    step(1'b1, 64'h0000_0000_0000_12F0, 3'd0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1);
    chk("byte_signed", 32'(rf_wdata), 32'h0000FFF0);
    step(1'b1, 64'h0000_0000_0000_12F0, 3'd0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0);
    chk("byte_zero", 32'(rf_wdata), 32'h000000F0);
`endif

    // Reset in the middle of a stall drops the held op
    step(1'b1, alu_src(16'hDEAD), 3'd1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    do_reset();
    step(1'b0, '0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("midrst_cnt", 32'(retire_cnt), 32'd0);
    chk("midrst_we",  {31'd0, rf_we},  32'd0);

    // 17 retirements on a 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++)
      step(1'b1, alu_src(16'(i)), 3'd1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("wrap_cnt", 32'(retire_cnt), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
           3'($urandom_range(0, 9) < 8 ? $urandom_range(0, 3) : $urandom_range(4, 7)),
           1'($urandom), 3'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
